intt_gs_butterfly: RTL and testbench
====================================

// Module: intt_gs_butterfly
// PURPOSE
// - Pipelined Gentleman-Sande (inverse-NTT) butterfly for Kyber; the inverse-direction counterpart of the forward modular-add path.
// - Computes out_a = (a + b) mod Q and out_b = ((a - b) mod Q) * zeta mod Q, using Barrett reduction.
// - Sits between the INTT coefficient-RAM read port and the write-back port. Uses a valid/ready stream with a pass-through tag for the write-back address.
// PARAMETERS
// - Q          3329   Kyber modulus
// - W          12     coefficient width, ceil(log2(Q))
// - BARRETT_M  5039   floor(2^24 / Q), Barrett constant
// - TAG_W      8      width of the sideband tag (RAM address/index)
// PORTS
// - clk        in   1      single clock, rising-edge
// - rst        in   1      asynchronous, active-high reset
// - in_valid   in   1      input beat valid
// - in_ready   out  1      block can accept a beat this cycle
// - in_a       in   W      coefficient a, must be < Q
// - in_b       in   W      coefficient b, must be < Q
// - in_zeta    in   W      twiddle factor, must be < Q
// - in_tag     in   TAG_W  sideband, returned unchanged with the result
// - out_valid  out  1      result beat valid
// - out_ready  in   1      downstream accepts the result
// - out_a      out  W      (a+b) mod Q
// - out_b      out  W      (a-b)*zeta mod Q
// - out_tag    out  TAG_W  tag of this result
// BEHAVIOUR
// - Reset (async, active-high): all stage-valid bits clear; out_valid=0; out_a=out_b=0; out_tag=0.
//   - in_ready=1 from the first clock edge after rst deasserts.
//   - Reset mid-stream discards every in-flight beat; no partial beat is emitted.
// - Handshake: a transfer occurs when valid && ready on the same rising edge.
//   - Once asserted, out_valid and out_* hold stable until out_ready=1.
// - Flow control: adv = !(out_valid && !out_ready); in_ready = adv.
//   - All stages advance together when adv=1 and freeze when adv=0.
//   - Bubbles (stage-valid=0) propagate; they are not squeezed out.
// - Latency: exactly 4 cycles from input handshake to out_valid, with no stalls. Throughput is 1 beat/cycle.
// - Stage 1:
//   - s = a+b (13b); sum = (s >= Q) ? s-Q : s.
//   - diff = (a >= b) ? a-b : a-b+Q (13b intermediate, result < Q).
//   - Register sum, diff, zeta, tag.
// - Stage 2: p = diff*zeta (24b, p < Q^2 < 2^24). Register p, sum, tag.
// - Stage 3: t = (p*BARRETT_M) >> 24 (37b product, 13b t). Register p, t, sum, tag.
// - Stage 4:
//   - r = p - t*Q; guaranteed 0 <= r < 2Q.
//   - out_b = (r >= Q) ? r-Q : r; out_a = sum; out_tag = tag.
// - Boundaries:
//   - a+b == Q -> 0.
//   - a == b -> out_b = 0.
//   - zeta == 0 -> out_b = 0.
//   - Every output is < Q for every legal input.
// - Simultaneous events: input accept and output drain in the same cycle are legal and lose nothing.
// - Inputs >= Q are illegal; the result is undefined (no error flag). The bench asserts against them.
// STRUCTURE
// - Package kyber_pkg holds:
//   - constants KYBER_Q=3329, COEF_W=12, BARRETT_M=5039, BARRETT_SHIFT=24;
//   - typedef logic [COEF_W-1:0] coef_t.
// - Sub-module barrett_reduce_24: 2-stage pipelined p mod Q. It forms stages 3-4 and has an enable input driven by adv.
//   - It is reused later by the forward NTT butterfly.
// - Stages 1-2, valid bits and flow control stay in this module.
// TESTING
// - T1 basic: a=5, b=3, zeta=17, tag=0x11 -> 4 cycles later out_a=8, out_b=34, out_tag=0x11.
// - T2 subtract wrap: a=3, b=5, zeta=1 -> out_a=8, out_b=3327.
// - T3 add wrap and Barrett correction:
//   - a=3000, b=1000, zeta=1 -> out_a=671, out_b=2000;
//   - a=1, b=3328, zeta=3328 -> out_a=0, out_b=3327.
// - T4 backpressure: 8 back-to-back beats, out_ready=0 for cycles 6-9.
//   - All 8 results emerge in order, correct, none duplicated.
//   - in_ready=0 while out_valid && !out_ready.
// - T5 reset mid-stream: assert rst with 3 beats in flight.
//   - out_valid=0 asynchronously; nothing emitted after release.
//   - Next beat returns after 4 cycles.
// - T6 random: 10k beats, random in_valid/out_ready.
//   - Scoreboard against the golden model ((a+b)%Q, ((a-b+Q)%Q*zeta)%Q).
//   - Zero mismatches; cover a==b, zeta=0 and a+b==Q.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic constants and the coefficient type used by the
// NTT/INTT butterflies and their reduction helpers.
package kyber_pkg;

    localparam int KYBER_Q       = 3329;
    localparam int COEF_W        = 12;
    localparam int BARRETT_M     = 5039;
    localparam int BARRETT_SHIFT = 24;
    localparam int PROD_W        = 24;

    typedef logic [COEF_W-1:0] coef_t;

endpackage

// File: rtl/barrett_reduce_24.sv
// Two-stage pipelined Barrett reduction of a product p < Q^2 down to p mod Q.
// The enable freezes both stages together so it can sit inside a stalled
// pipeline without losing or duplicating data.
module barrett_reduce_24
    import kyber_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [PROD_W-1:0] p_in,
    output coef_t             r_out
);

    localparam logic [12:0] Q13 = 13'(KYBER_Q);

    logic [PROD_W-1:0] p_q, p_d;
    logic [12:0]       t_q, t_d;
    coef_t             r_q, r_d;
    logic [12:0]       r_full;

    // Quotient estimate t = floor(p*M / 2^24) and the remainder correction.
    always_comb begin
        p_d    = p_q;
        t_d    = t_q;
        r_d    = r_q;
        r_full = 13'(25'(p_q) - 25'(t_q) * 25'(KYBER_Q));
        if (en) begin
            p_d = p_in;
            t_d = 13'((37'(p_in) * 37'(BARRETT_M)) >> BARRETT_SHIFT);
            r_d = (r_full >= Q13) ? coef_t'(r_full - Q13) : coef_t'(r_full);
        end
    end

    // Pipeline registers for both reduction stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= '0;
            t_q <= '0;
            r_q <= '0;
        end else begin
            p_q <= p_d;
            t_q <= t_d;
            r_q <= r_d;
        end
    end

    assign r_out = r_q;

endmodule

// File: rtl/intt_gs_butterfly.sv
// Gentleman-Sande inverse-NTT butterfly: out_a = (a+b) mod Q and
// out_b = (a-b)*zeta mod Q, four stages deep with a valid/ready stream.
// Every stage advances or freezes together, so bubbles are kept in place.
module intt_gs_butterfly
    import kyber_pkg::*;
#(
    parameter int TAG_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_a,
    input  logic [COEF_W-1:0] in_b,
    input  logic [COEF_W-1:0] in_zeta,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [COEF_W-1:0] out_a,
    output logic [COEF_W-1:0] out_b,
    output logic [TAG_W-1:0]  out_tag
);

    localparam logic [12:0] Q13 = 13'(KYBER_Q);

    logic              adv;
    logic [12:0]       add_full, diff_full;

    logic              s1_valid_q, s1_valid_d;
    coef_t             s1_sum_q, s1_sum_d, s1_diff_q, s1_diff_d, s1_zeta_q, s1_zeta_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

    logic              s2_valid_q, s2_valid_d;
    logic [PROD_W-1:0] s2_p_q, s2_p_d;
    coef_t             s2_sum_q, s2_sum_d;
    logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;

    logic              s3_valid_q, s3_valid_d;
    coef_t             s3_sum_q, s3_sum_d;
    logic [TAG_W-1:0]  s3_tag_q, s3_tag_d;

    logic              out_valid_q, out_valid_d;
    coef_t             out_a_q, out_a_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;

    // The whole pipe moves unless a held result is waiting on downstream.
    always_comb begin
        adv      = !(out_valid_q && !out_ready);
        in_ready = adv;
    end

    // Stage 1: modular sum and modular difference of the incoming pair.
    always_comb begin
        add_full   = {1'b0, in_a} + {1'b0, in_b};
        diff_full  = (in_a >= in_b) ? ({1'b0, in_a} - {1'b0, in_b})
                                    : ({1'b0, in_a} + Q13 - {1'b0, in_b});
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s1_diff_d  = s1_diff_q;
        s1_zeta_d  = s1_zeta_q;
        s1_tag_d   = s1_tag_q;
        if (adv) begin
            s1_valid_d = in_valid;
            s1_sum_d   = (add_full >= Q13) ? coef_t'(add_full - Q13) : coef_t'(add_full);
            s1_diff_d  = coef_t'(diff_full);
            s1_zeta_d  = in_zeta;
            s1_tag_d   = in_tag;
        end
    end

    // Stages 2-4 sideband: twiddle multiply plus sum/tag/valid alignment
    // alongside the two Barrett stages.
    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_p_d      = s2_p_q;
        s2_sum_d    = s2_sum_q;
        s2_tag_d    = s2_tag_q;
        s3_valid_d  = s3_valid_q;
        s3_sum_d    = s3_sum_q;
        s3_tag_d    = s3_tag_q;
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_tag_d   = out_tag_q;
        if (adv) begin
            s2_valid_d  = s1_valid_q;
            s2_p_d      = 24'(s1_diff_q) * 24'(s1_zeta_q);
            s2_sum_d    = s1_sum_q;
            s2_tag_d    = s1_tag_q;
            s3_valid_d  = s2_valid_q;
            s3_sum_d    = s2_sum_q;
            s3_tag_d    = s2_tag_q;
            out_valid_d = s3_valid_q;
            out_a_d     = s3_sum_q;
            out_tag_d   = s3_tag_q;
        end
    end

    // All pipeline state; reset drops every in-flight beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_diff_q   <= '0;
            s1_zeta_q   <= '0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_p_q      <= '0;
            s2_sum_q    <= '0;
            s2_tag_q    <= '0;
            s3_valid_q  <= 1'b0;
            s3_sum_q    <= '0;
            s3_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_tag_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_diff_q   <= s1_diff_d;
            s1_zeta_q   <= s1_zeta_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_p_q      <= s2_p_d;
            s2_sum_q    <= s2_sum_d;
            s2_tag_q    <= s2_tag_d;
            s3_valid_q  <= s3_valid_d;
            s3_sum_q    <= s3_sum_d;
            s3_tag_q    <= s3_tag_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_tag_q   <= out_tag_d;
        end
    end

    barrett_reduce_24 u_barrett (
        .clk   (clk),
        .rst   (rst),
        .en    (adv),
        .p_in  (s2_p_q),
        .r_out (out_b)
    );

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_intt_gs_butterfly.sv
// Directed and randomised checks of the INTT Gentleman-Sande butterfly.
module tb_intt_gs_butterfly;

    localparam int Q = 3329;
    localparam int N_RANDOM = 10000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_a = '0;
    logic [11:0] in_b = '0;
    logic [11:0] in_zeta = '0;
    logic [7:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] out_a;
    logic [11:0] out_b;
    logic [7:0]  out_tag;

    int pass_count = 0;
    int check_count = 0;

    intt_gs_butterfly #(.TAG_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_zeta   (in_zeta),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_tag   (out_tag)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Legal inputs must be reduced coefficients.
    always @(negedge clk) begin
        if (!rst && in_valid) begin
            assert (in_a < Q && in_b < Q && in_zeta < Q)
                else $error("[TB] illegal coefficient driven a=%0d b=%0d zeta=%0d", in_a, in_b, in_zeta);
        end
    end

    function automatic int gold_a(int a, int b);
        return (a + b) % Q;
    endfunction

    function automatic int gold_b(int a, int b, int z);
        return (((a - b + Q) % Q) * z) % Q;
    endfunction

    // Push one beat through an otherwise idle pipe and report the result.
    task automatic send_single(input int a, input int b, input int z, input int tag,
                               output int lat, output int oa, output int ob,
                               output int otag, output logic dup);
        in_a = 12'(a); in_b = 12'(b); in_zeta = 12'(z); in_tag = 8'(tag);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        oa = int'(out_a); ob = int'(out_b); otag = int'(out_tag);
        @(posedge clk); #1;
        dup = out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_count++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid);
        else pass_count++;
        check_count++;
        if ({out_a, out_b, out_tag} !== 32'h0)
            $display("[TB] FAIL reset_outputs got a=%0d b=%0d tag=%0h want 0/0/0", out_a, out_b, out_tag);
        else pass_count++;
        rst = 1'b0;
        @(posedge clk); #1;
        check_count++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", in_ready);
        else pass_count++;
    endtask

    task automatic test_basic();
        int lat, oa, ob, otag;
        logic dup;
        send_single(5, 3, 17, 8'h11, lat, oa, ob, otag, dup);
        check_count++;
        if (lat !== 4) $display("[TB] FAIL basic_latency got %0d want 4", lat);
        else pass_count++;
        check_count++;
        if (oa !== 8 || ob !== 34 || otag !== 8'h11)
            $display("[TB] FAIL basic_result got a=%0d b=%0d tag=%0h want 8/34/11", oa, ob, otag);
        else pass_count++;
        check_count++;
        if (dup !== 1'b0) $display("[TB] FAIL basic_single_beat got out_valid=%b want 0", dup);
        else pass_count++;
    endtask

    task automatic test_vectors();
        int va[8]  = '{3, 3000, 1,    1234, 100, 3328, 3328, 0};
        int vb[8]  = '{5, 1000, 3328, 1234, 200, 1,    3328, 1};
        int vz[8]  = '{1, 1,    3328, 999,  0,   5,    3328, 3328};
        int ea[8]  = '{8, 671,  0,    2468, 300, 0,    3327, 1};
        int eb[8]  = '{3327, 2000, 3327, 0, 0,   3319, 0,    1};
        int lat, oa, ob, otag;
        logic dup;
        for (int i = 0; i < 8; i++) begin
            send_single(va[i], vb[i], vz[i], 8'h40 + i, lat, oa, ob, otag, dup);
            check_count++;
            if (oa !== ea[i] || ob !== eb[i] || otag !== 8'h40 + i || lat !== 4)
                $display("[TB] FAIL vector_%0d got a=%0d b=%0d tag=%0h lat=%0d want %0d/%0d/%0h/4",
                         i, oa, ob, otag, lat, ea[i], eb[i], 8'h40 + i);
            else pass_count++;
        end
    endtask

    task automatic test_backpressure();
        int va[8] = '{10, 4,    2000, 7,   50, 3328, 1,    1664};
        int vb[8] = '{4,  10,   1329, 7,   20, 0,    2,    1665};
        int vz[8] = '{2,  1,    3,    100, 0,  2,    3328, 2};
        int ea[8] = '{14, 14,   0,    14,  70, 3328, 3,    0};
        int eb[8] = '{12, 3323, 2013, 0,   0,  3327, 1,    3327};
        int k = 0, j = 0;
        logic prev_stall = 1'b0;
        logic [31:0] held = '0;
        logic acc;
        for (int cyc = 0; cyc < 40 && j < 8; cyc++) begin
            in_valid = (k < 8);
            if (k < 8) begin
                in_a = 12'(va[k]); in_b = 12'(vb[k]); in_zeta = 12'(vz[k]); in_tag = 8'(8'h20 + k);
            end
            out_ready = !(cyc >= 6 && cyc <= 9);
            #1;
            if (out_valid && !out_ready) begin
                check_count++;
                if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready cycle %0d got %b want 0", cyc, in_ready);
                else pass_count++;
            end
            if (prev_stall) begin
                check_count++;
                if ({out_a, out_b, out_tag} !== held || out_valid !== 1'b1)
                    $display("[TB] FAIL bp_hold cycle %0d got v=%b %h want v=1 %h", cyc, out_valid,
                             {out_a, out_b, out_tag}, held);
                else pass_count++;
            end
            if (out_valid && out_ready) begin
                check_count++;
                if (out_a !== 12'(ea[j]) || out_b !== 12'(eb[j]) || out_tag !== 8'(8'h20 + j))
                    $display("[TB] FAIL bp_beat_%0d got a=%0d b=%0d tag=%0h want %0d/%0d/%0h",
                             j, out_a, out_b, out_tag, ea[j], eb[j], 8'h20 + j);
                else pass_count++;
                j++;
            end
            prev_stall = out_valid && !out_ready;
            held = {out_a, out_b, out_tag};
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) k++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check_count++;
        if (j !== 8) $display("[TB] FAIL bp_count got %0d want 8", j);
        else pass_count++;
        #1;
        check_count++;
        if (out_valid !== 1'b0) $display("[TB] FAIL bp_no_duplicate got out_valid=%b want 0", out_valid);
        else pass_count++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midstream();
        int lat, oa, ob, otag;
        logic dup;
        logic seen = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_a = 12'(k * 3); in_b = 12'(k); in_zeta = 12'd7; in_tag = 8'(k);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_count++;
        if (out_valid !== 1'b1) $display("[TB] FAIL midrst_pre_valid got %b want 1", out_valid);
        else pass_count++;
        rst = 1'b1;
        #1;
        check_count++;
        if (out_valid !== 1'b0 || {out_a, out_b, out_tag} !== 32'h0)
            $display("[TB] FAIL midrst_async got v=%b a=%0d b=%0d tag=%0h want 0/0/0/0",
                     out_valid, out_a, out_b, out_tag);
        else pass_count++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        check_count++;
        if (seen !== 1'b0) $display("[TB] FAIL midrst_flushed got out_valid seen=%b want 0", seen);
        else pass_count++;
        send_single(20, 7, 3, 8'h55, lat, oa, ob, otag, dup);
        check_count++;
        if (lat !== 4 || oa !== 27 || ob !== 39 || otag !== 8'h55)
            $display("[TB] FAIL midrst_next got lat=%0d a=%0d b=%0d tag=%0h want 4/27/39/55", lat, oa, ob, otag);
        else pass_count++;
    endtask

    task automatic test_random();
        logic [31:0] exp_q[$];
        logic [31:0] exp;
        int sent = 0, got = 0, cyc = 0;
        int a, b, z, mode;
        int cov_eq = 0, cov_z0 = 0, cov_sq = 0;
        while (got < N_RANDOM && cyc < 60000) begin
            in_valid = (sent < N_RANDOM) && ($urandom_range(0, 3) != 0);
            mode = int'($urandom_range(0, 9));
            a = int'($urandom_range(0, Q - 1));
            b = int'($urandom_range(0, Q - 1));
            z = int'($urandom_range(0, Q - 1));
            if (mode == 0) b = a;
            else if (mode == 1) z = 0;
            else if (mode == 2) begin
                a = int'($urandom_range(1, Q - 1));
                b = Q - a;
            end
            in_a = 12'(a); in_b = 12'(b); in_zeta = 12'(z); in_tag = 8'(sent);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                check_count++;
                if (exp_q.size() == 0) begin
                    $display("[TB] FAIL rand_unexpected got a=%0d b=%0d tag=%0h want no beat",
                             out_a, out_b, out_tag);
                end else begin
                    exp = exp_q.pop_front();
                    if ({out_a, out_b, out_tag} !== exp)
                        $display("[TB] FAIL rand_beat_%0d got a=%0d b=%0d tag=%0h want %0d/%0d/%0h",
                                 got, out_a, out_b, out_tag, exp[31:20], exp[19:8], exp[7:0]);
                    else pass_count++;
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({12'(gold_a(a, b)), 12'(gold_b(a, b, z)), 8'(sent)});
                if (a == b) cov_eq++;
                if (z == 0) cov_z0++;
                if (a + b == Q) cov_sq++;
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check_count++;
        if (got !== N_RANDOM || exp_q.size() !== 0)
            $display("[TB] FAIL rand_drain got %0d beats, %0d pending want %0d/0", got, exp_q.size(), N_RANDOM);
        else pass_count++;
        $display("[TB] random coverage a==b:%0d zeta==0:%0d a+b==Q:%0d", cov_eq, cov_z0, cov_sq);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
